// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: load/clamp, borrow-chain decrement, pause,
// optional auto-reload, one-cycle timeout pulse and sticky expired level.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reconfig,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  tick,
  input  logic                  pause,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  timeout,
  output logic                  expired
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} stateT;

  stateT          state, stateNext;
  logic [W-1:0]   reloadReg, reloadNext, countNext;
  logic [W-1:0]   loadClamped, decremented;
  logic           timeoutNext;

  function automatic logic [W-1:0] clampBcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // Digit 0 always takes the borrow; a zero digit wraps to 9 and passes it on.
  function automatic logic [W-1:0] decBcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    stateNext   = state;
    countNext   = count;
    reloadNext  = reloadReg;
    timeoutNext = 1'b0;
    loadClamped = clampBcd(load_value);
    decremented = decBcd(count);

    if (reconfig) begin
      countNext  = loadClamped;
      reloadNext = loadClamped;
      stateNext  = (loadClamped != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        RUN: begin
          if (pause) begin
            stateNext = PAUSED;
          end else if (tick) begin
            if (decremented == '0) begin
              timeoutNext = 1'b1;
              if (auto_reload) begin
                countNext = reloadReg;
              end else begin
                countNext = '0;
                stateNext = EXPIRED;
              end
            end else begin
              countNext = decremented;
            end
          end
        end
        PAUSED: begin
          if (!pause) stateNext = RUN;
        end
        default: ;
      endcase
    end
  end

  // running/expired are registered from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      reloadReg <= '0;
      timeout   <= 1'b0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      reloadReg <= reloadNext;
      timeout   <= timeoutNext;
      running   <= (stateNext == RUN);
      expired   <= (stateNext == EXPIRED);
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: directed scenarios plus random stimulus checked against
// an integer-arithmetic model of the timer.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reconfig2 = 1'b0, tick2 = 1'b0, pause2 = 1'b0, autoReload2 = 1'b0;
  logic [7:0]  loadValue2 = '0;
  logic [7:0]  count2;
  logic        running2, timeout2, expired2;
  logic        reconfig4 = 1'b0, tick4 = 1'b0, pause4 = 1'b0, autoReload4 = 1'b0;
  logic [15:0] loadValue4 = '0;
  logic [15:0] count4;
  logic        running4, timeout4, expired4;

  int checks = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
  int mVal, mReload, mMode;
  bit mTo;
  int pulseCount;
  bit zeroSeen;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .reconfig(reconfig2), .load_value(loadValue2),
    .tick(tick2), .pause(pause2), .auto_reload(autoReload2),
    .count(count2), .running(running2), .timeout(timeout2), .expired(expired2)
  );

  bcd_countdown_timer #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .reconfig(reconfig4), .load_value(loadValue4),
    .tick(tick4), .pause(pause4), .auto_reload(autoReload4),
    .count(count4), .running(running4), .timeout(timeout4), .expired(expired4)
  );

  function automatic int fromBcd(input logic [31:0] x, input int nd);
    int v = 0, p = 1, d;
    for (int i = 0; i < nd; i++) begin
      d = int'(x[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] toBcd(input int v, input int nd);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkModel2(input string tag);
    check({tag, ".count"},   32'(count2),   toBcd(mVal, 2));
    check({tag, ".running"}, 32'(running2), 32'(mMode == M_RUN));
    check({tag, ".timeout"}, 32'(timeout2), 32'(mTo));
    check({tag, ".expired"}, 32'(expired2), 32'(mMode == M_EXP));
  endtask

  task automatic modelReset();
    mVal = 0; mReload = 0; mMode = M_IDLE; mTo = 0;
  endtask

  // One clock edge on the DIGITS=2 instance, model update, then check.
  task automatic step2(input string tag, input bit rc, input logic [7:0] lv,
                       input bit tk, input bit ps, input bit ar);
    @(negedge clk);
    reconfig2 = rc; loadValue2 = lv; tick2 = tk; pause2 = ps; autoReload2 = ar;
    @(posedge clk);
    mTo = 0;
    if (rc) begin
      mVal = fromBcd(32'(lv), 2);
      mReload = mVal;
      mMode = (mVal != 0) ? M_RUN : M_IDLE;
    end else if (mMode == M_RUN) begin
      if (ps) mMode = M_PAUSED;
      else if (tk) begin
        mVal = mVal - 1;
        if (mVal == 0) begin
          mTo = 1;
          if (ar) mVal = mReload;
          else mMode = M_EXP;
        end
      end
    end else if (mMode == M_PAUSED && !ps) begin
      mMode = M_RUN;
    end
    #1;
    if (timeout2 === 1'b1) pulseCount++;
    if (count2 === 8'h00) zeroSeen = 1;
    checkModel2(tag);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkModel2("reset");
    check("reset.count4", 32'(count4), 32'h0);
    rst = 1'b1;

    // 10 down to 0, single timeout, then expired holds.
    step2("t1.load", 1, 8'h10, 0, 0, 0);
    check("t1.loaded", 32'(count2), 32'h10);
    pulseCount = 0;
    for (int i = 0; i < 10; i++) step2("t1.tick", 0, 8'h00, 1, 0, 0);
    check("t1.count", 32'(count2), 32'h00);
    check("t1.expired", 32'(expired2), 32'h1);
    step2("t1.hold", 0, 8'h00, 1, 0, 0);
    check("t1.pulses", 32'(pulseCount), 32'd1);

    // Clamp and zero load.
    step2("t2.clamp", 1, 8'h3A, 0, 0, 0);
    check("t2.count39", 32'(count2), 32'h39);
    step2("t2.zero", 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step2("t2.idleTick", 0, 8'h00, 1, 0, 0);
    check("t2.count00", 32'(count2), 32'h00);

    // Auto-reload: three pulses, never showing 00.
    step2("t3.load", 1, 8'h05, 0, 0, 1);
    pulseCount = 0; zeroSeen = 0;
    for (int i = 0; i < 15; i++) step2("t3.tick", 0, 8'h00, 1, 0, 1);
    check("t3.pulses", 32'(pulseCount), 32'd3);
    check("t3.noZero", 32'(zeroSeen), 32'd0);
    check("t3.count05", 32'(count2), 32'h05);

    // Pause mid-count.
    step2("t4.load", 1, 8'h20, 0, 0, 0);
    for (int i = 0; i < 3; i++) step2("t4.tick", 0, 8'h00, 1, 0, 0);
    check("t4.count17", 32'(count2), 32'h17);
    for (int i = 0; i < 5; i++) step2("t4.paused", 0, 8'h00, 1, 1, 0);
    check("t4.hold17", 32'(count2), 32'h17);
    for (int i = 0; i < 3; i++) step2("t4.resume", 0, 8'h00, 1, 0, 0);
    check("t4.count15", 32'(count2), 32'h15);

    // Load beats final tick; then async reset mid-count.
    step2("t5.load", 1, 8'h01, 0, 0, 0);
    pulseCount = 0;
    step2("t5.race", 1, 8'h07, 1, 0, 0);
    check("t5.count07", 32'(count2), 32'h07);
    step2("t5.tick", 0, 8'h00, 1, 0, 0);
    check("t5.noPulse", 32'(pulseCount), 32'd0);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkModel2("t5.asyncRst");
    @(negedge clk);
    rst = 1'b1;

    // Four-digit borrow chain.
    @(negedge clk); reconfig4 = 1; loadValue4 = 16'h1000;
    @(negedge clk); reconfig4 = 0; tick4 = 1;
    @(negedge clk); tick4 = 0;
    check("t6.count4", 32'(count4), toBcd(fromBcd(32'h1000, 4) - 1, 4));
    check("t6.running4", 32'(running4), 32'h1);

    // Random traffic on the two-digit instance.
    for (int i = 0; i < 400; i++) begin
      step2("rand", ($urandom_range(15) == 0), 8'($urandom), ($urandom_range(3) != 0),
            ($urandom_range(7) == 0), 1'($urandom));
    end

    @(negedge clk);
    tick2 = 0; reconfig2 = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
